// File: rtl/usb2_ep_ctrl.sv
// USB 2.0 endpoint controller: routes the selected endpoint's status to the packet
// handler, owns the IN data toggles and runs the commit/arm handshakes with timeouts.

module usb2_ep_tog (
  input  logic phy_clk,
  input  logic reset_n,
  input  logic clr,
  input  logic act,
  input  logic iso,
  output logic tog
);
  always_ff @(posedge phy_clk) begin
    if (!reset_n)         tog <= 1'b0;
    else if (clr)         tog <= 1'b0;
    else if (act && !iso) tog <= ~tog;
  end
endmodule

module usb2_ep_ctrl #(
  parameter int NUM_EP  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     phy_clk,
  input  logic                     reset_n,
  input  logic [3:0]               sel_endp,
  input  logic                     buf_in_commit,
  input  logic [10:0]              buf_in_commit_len,
  output logic                     buf_in_commit_ack,
  input  logic                     buf_out_arm,
  output logic                     buf_out_arm_ack,
  input  logic                     data_toggle_act,
  output logic                     buf_in_ready,
  output logic                     buf_out_hasdata,
  output logic [10:0]              buf_out_len,
  output logic [1:0]               endp_mode,
  output logic [1:0]               data_toggle,
  input  logic [NUM_EP-1:0]        ep_in_ready,
  input  logic [NUM_EP-1:0]        ep_out_hasdata,
  input  logic [NUM_EP-1:0][10:0]  ep_out_len,
  input  logic [NUM_EP-1:0][1:0]   ep_mode,
  input  logic [NUM_EP-1:0]        ep_toggle_clr,
  output logic [NUM_EP-1:0]        ep_in_commit,
  output logic [10:0]              ep_in_commit_len,
  input  logic [NUM_EP-1:0]        ep_in_commit_ack,
  output logic [NUM_EP-1:0]        ep_out_arm,
  input  logic [NUM_EP-1:0]        ep_out_arm_ack,
  output logic                     err_commit,
  output logic                     err_arm
);
  localparam logic [1:0] MODE_ISO = 2'd1;
  localparam int         HS       = 2;  // channel 0 = commit, channel 1 = arm

  typedef enum logic {HS_IDLE = 1'b0, HS_WAIT = 1'b1} hs_st_e;

  logic [3:0]        sel_q;
  logic              sel_ok;
  logic [NUM_EP-1:0] tog, tog_act, ep_iso;

  logic              rt_rdy, rt_has;
  logic [10:0]       rt_len;
  logic [1:0]        rt_mode, rt_tog;

  logic [HS-1:0]             hs_req, hs_ack, hs_err;
  logic [HS-1:0][NUM_EP-1:0] hs_ep_ack, hs_ep_pulse;

  assign sel_ok = ({1'b0, sel_q} < 5'(NUM_EP));

  always_ff @(posedge phy_clk) begin
    if (!reset_n) sel_q <= '0;
    else          sel_q <= sel_endp;
  end

  // Status mux: no match (sel_q out of range) leaves everything at zero.
  always_comb begin
    rt_rdy  = 1'b0;
    rt_has  = 1'b0;
    rt_len  = '0;
    rt_mode = '0;
    rt_tog  = '0;
    for (int n = 0; n < NUM_EP; n++) begin
      if (sel_q == 4'(n)) begin
        rt_rdy  = ep_in_ready[n];
        rt_has  = ep_out_hasdata[n];
        rt_len  = ep_out_len[n];
        rt_mode = ep_mode[n];
        rt_tog  = {1'b0, tog[n] & ~ep_iso[n]};
      end
    end
  end

  always_ff @(posedge phy_clk) begin
    if (!reset_n) begin
      buf_in_ready    <= 1'b0;
      buf_out_hasdata <= 1'b0;
      buf_out_len     <= '0;
      endp_mode       <= '0;
      data_toggle     <= '0;
    end else begin
      buf_in_ready    <= rt_rdy;
      buf_out_hasdata <= rt_has;
      buf_out_len     <= rt_len;
      endp_mode       <= rt_mode;
      data_toggle     <= rt_tog;
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_EP; n++) begin
      ep_iso[n]  = (ep_mode[n] == MODE_ISO);
      tog_act[n] = data_toggle_act && (sel_q == 4'(n));
    end
  end

  for (genvar n = 0; n < NUM_EP; n++) begin : g_tog
    usb2_ep_tog u_tog (
      .phy_clk (phy_clk),
      .reset_n (reset_n),
      .clr     (ep_toggle_clr[n]),
      .act     (tog_act[n]),
      .iso     (ep_iso[n]),
      .tog     (tog[n])
    );
  end

  assign hs_req            = {buf_out_arm, buf_in_commit};
  assign hs_ep_ack         = {ep_out_arm_ack, ep_in_commit_ack};
  assign ep_in_commit      = hs_ep_pulse[0];
  assign ep_out_arm        = hs_ep_pulse[1];
  assign buf_in_commit_ack = hs_ack[0];
  assign buf_out_arm_ack   = hs_ack[1];
  assign err_commit        = hs_err[0];
  assign err_arm           = hs_err[1];

  for (genvar g = 0; g < HS; g++) begin : g_hs
    hs_st_e            st, st_nxt;
    logic [3:0]        ep_q;
    logic [9:0]        tmr;
    logic              start, drop, ack_hit, tmo;
    logic [NUM_EP-1:0] sel_oh, ep_oh, pulse_q;
    logic              ack_q, err_q;

    assign hs_ep_pulse[g] = pulse_q;
    assign hs_ack[g]      = ack_q;
    assign hs_err[g]      = err_q;

    always_ff @(posedge phy_clk) begin
      if (!reset_n) begin
        st      <= HS_IDLE;
        ep_q    <= '0;
        tmr     <= '0;
        pulse_q <= '0;
        ack_q   <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        st <= st_nxt;
        if (start) ep_q <= sel_q;
        if (start)                tmr <= '0;
        else if (st == HS_WAIT)   tmr <= tmr + 10'd1;
        pulse_q <= start ? sel_oh : '0;
        ack_q   <= ack_hit;
        err_q   <= err_q | drop | tmo;
      end
    end

    always_comb begin
      st_nxt = st;
      case (st)
        HS_IDLE: if (start)          st_nxt = HS_WAIT;
        HS_WAIT: if (ack_hit || tmo) st_nxt = HS_IDLE;
        default:                     st_nxt = HS_IDLE;
      endcase
    end

    // Ack wins over a same-cycle timeout; any request not started is a drop.
    always_comb begin
      sel_oh  = (NUM_EP)'(1) << sel_q;
      ep_oh   = (NUM_EP)'(1) << ep_q;
      start   = (st == HS_IDLE) && hs_req[g] && sel_ok;
      drop    = hs_req[g] && !start;
      ack_hit = (st == HS_WAIT) && |(hs_ep_ack[g] & ep_oh);
      tmo     = (st == HS_WAIT) && !ack_hit && (tmr == 10'(TIMEOUT - 1));
    end

    if (g == 0) begin : g_len
      always_ff @(posedge phy_clk) begin
        if (!reset_n)   ep_in_commit_len <= '0;
        else if (start) ep_in_commit_len <= buf_in_commit_len;
      end
    end
  end

endmodule

// File: tb/tb_usb2_ep_ctrl.sv
// Scoreboard bench for usb2_ep_ctrl: stimulus queues expected pulses and status
// values by cycle; a negedge monitor compares and flags any unexpected pulse.

module tb_usb2_ep_ctrl;
  localparam int NUM_EP  = 4;
  localparam int TIMEOUT = 64;

  localparam int F_RDY = 0, F_HAS = 1, F_LEN = 2, F_MODE = 3, F_TOG = 4,
                 F_ERRC = 5, F_ERRA = 6, F_CLEN = 7;
  localparam int K_CMT = 0, K_CACK = 1, K_ARM = 2, K_AACK = 3;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic                    phy_clk = 1'b0;
  logic                    reset_n;
  logic [3:0]              sel_endp;
  logic                    buf_in_commit;
  logic [10:0]             buf_in_commit_len;
  logic                    buf_in_commit_ack;
  logic                    buf_out_arm;
  logic                    buf_out_arm_ack;
  logic                    data_toggle_act;
  logic                    buf_in_ready;
  logic                    buf_out_hasdata;
  logic [10:0]             buf_out_len;
  logic [1:0]              endp_mode;
  logic [1:0]              data_toggle;
  logic [NUM_EP-1:0]       ep_in_ready;
  logic [NUM_EP-1:0]       ep_out_hasdata;
  logic [NUM_EP-1:0][10:0] ep_out_len;
  logic [NUM_EP-1:0][1:0]  ep_mode;
  logic [NUM_EP-1:0]       ep_toggle_clr;
  logic [NUM_EP-1:0]       ep_in_commit;
  logic [10:0]             ep_in_commit_len;
  logic [NUM_EP-1:0]       ep_in_commit_ack;
  logic [NUM_EP-1:0]       ep_out_arm;
  logic [NUM_EP-1:0]       ep_out_arm_ack;
  logic                    err_commit;
  logic                    err_arm;

  exp_t evt_q[$];
  exp_t st_q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 1'b0;

  usb2_ep_ctrl #(.NUM_EP(NUM_EP), .TIMEOUT(TIMEOUT)) dut (
    .phy_clk           (phy_clk),
    .reset_n           (reset_n),
    .sel_endp          (sel_endp),
    .buf_in_commit     (buf_in_commit),
    .buf_in_commit_len (buf_in_commit_len),
    .buf_in_commit_ack (buf_in_commit_ack),
    .buf_out_arm       (buf_out_arm),
    .buf_out_arm_ack   (buf_out_arm_ack),
    .data_toggle_act   (data_toggle_act),
    .buf_in_ready      (buf_in_ready),
    .buf_out_hasdata   (buf_out_hasdata),
    .buf_out_len       (buf_out_len),
    .endp_mode         (endp_mode),
    .data_toggle       (data_toggle),
    .ep_in_ready       (ep_in_ready),
    .ep_out_hasdata    (ep_out_hasdata),
    .ep_out_len        (ep_out_len),
    .ep_mode           (ep_mode),
    .ep_toggle_clr     (ep_toggle_clr),
    .ep_in_commit      (ep_in_commit),
    .ep_in_commit_len  (ep_in_commit_len),
    .ep_in_commit_ack  (ep_in_commit_ack),
    .ep_out_arm        (ep_out_arm),
    .ep_out_arm_ack    (ep_out_arm_ack),
    .err_commit        (err_commit),
    .err_arm           (err_arm)
  );

  always #5 phy_clk = ~phy_clk;
  always @(posedge phy_clk) cyc <= cyc + 1;

  function automatic logic [31:0] stat_val(input int k);
    case (k)
      F_RDY:   return 32'(buf_in_ready);
      F_HAS:   return 32'(buf_out_hasdata);
      F_LEN:   return 32'(buf_out_len);
      F_MODE:  return 32'(endp_mode);
      F_TOG:   return 32'(data_toggle);
      F_ERRC:  return 32'(err_commit);
      F_ERRA:  return 32'(err_arm);
      F_CLEN:  return 32'(ep_in_commit_len);
      default: return '0;
    endcase
  endfunction

  function automatic void ex_st(input string nm, input int k, input int dt, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc + dt; e.kind = k; e.val = v; e.name = nm;
    st_q.push_back(e);
  endfunction

  function automatic void ex_ev(input string nm, input int k, input int dt, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc + dt; e.kind = k; e.val = v; e.name = nm;
    evt_q.push_back(e);
  endfunction

  // Monitor: every negedge, check due status items and all handshake pulses.
  logic [31:0] obs [4];
  bit          seen [4];
  always @(negedge phy_clk) begin
    obs[K_CMT]  = 32'(ep_in_commit);
    obs[K_CACK] = 32'(buf_in_commit_ack);
    obs[K_ARM]  = 32'(ep_out_arm);
    obs[K_AACK] = 32'(buf_out_arm_ack);
    for (int k = 0; k < 4; k++) seen[k] = 1'b0;
    for (int i = evt_q.size() - 1; i >= 0; i--) begin
      if (evt_q[i].cyc <= cyc) begin
        vectors++;
        seen[evt_q[i].kind] = 1'b1;
        if (evt_q[i].cyc < cyc || obs[evt_q[i].kind] !== evt_q[i].val) begin
          miscompares++;
          $display("FAIL %s @%0d: got %0h, required %0h", evt_q[i].name, cyc,
                   obs[evt_q[i].kind], evt_q[i].val);
        end
        evt_q.delete(i);
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (!seen[k] && obs[k] !== 32'd0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pulse_%0d @%0d: got %0h, required 0", k, cyc, obs[k]);
      end
    end
    for (int i = st_q.size() - 1; i >= 0; i--) begin
      if (st_q[i].cyc <= cyc) begin
        vectors++;
        if (stat_val(st_q[i].kind) !== st_q[i].val) begin
          miscompares++;
          $display("FAIL %s @%0d: got %0h, required %0h", st_q[i].name, cyc,
                   stat_val(st_q[i].kind), st_q[i].val);
        end
        st_q.delete(i);
      end
    end
    if (done || cyc > 5000) begin
      if (!done) begin
        vectors++;
        miscompares++;
        $display("FAIL watchdog: got cycle %0d, required end before 5000", cyc);
      end
      foreach (evt_q[i]) begin
        vectors++; miscompares++;
        $display("FAIL %s: got no check, required at cycle %0d", evt_q[i].name, evt_q[i].cyc);
      end
      foreach (st_q[i]) begin
        vectors++; miscompares++;
        $display("FAIL %s: got no check, required at cycle %0d", st_q[i].name, st_q[i].cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge phy_clk);
  endtask

  task automatic tog_step(input logic [NUM_EP-1:0] clr, input logic [31:0] exp_tog, input string nm);
    data_toggle_act = 1'b1;
    ep_toggle_clr   = clr;
    tick(1);
    data_toggle_act = 1'b0;
    ep_toggle_clr   = '0;
    ex_st(nm, F_TOG, 1, exp_tog);
  endtask

  int a;

  initial begin
    reset_n           = 1'b0;
    sel_endp          = 4'd2;
    buf_in_commit     = 1'b0;
    buf_in_commit_len = '0;
    buf_out_arm       = 1'b0;
    data_toggle_act   = 1'b0;
    ep_in_ready       = 4'b1011;
    ep_out_hasdata    = 4'b0100;
    ep_out_len[0] = 11'd8;  ep_out_len[1] = 11'd64;
    ep_out_len[2] = 11'd512; ep_out_len[3] = 11'd100;
    ep_mode[0] = 2'd0; ep_mode[1] = 2'd2; ep_mode[2] = 2'd2; ep_mode[3] = 2'd1;
    ep_toggle_clr     = '0;
    ep_in_commit_ack  = '0;
    ep_out_arm_ack    = '0;

    // reset state, then 2-cycle routing latency
    tick(2);
    ex_st("rst_ready", F_RDY, 1, 0);  ex_st("rst_hasdata", F_HAS, 1, 0);
    ex_st("rst_len", F_LEN, 1, 0);    ex_st("rst_tog", F_TOG, 1, 0);
    ex_st("rst_errc", F_ERRC, 1, 0);  ex_st("rst_erra", F_ERRA, 1, 0);
    ex_st("rst_clen", F_CLEN, 1, 0);
    tick(1);
    reset_n = 1'b1;
    ex_st("rt_has_early", F_HAS, 1, 0);
    ex_st("rt_has", F_HAS, 2, 1); ex_st("rt_len", F_LEN, 2, 512); ex_st("rt_mode", F_MODE, 2, 2);
    tick(3);

    // bulk toggle, clear, clear-over-act priority
    sel_endp = 4'd1;
    tick(2);
    ex_st("tog_init", F_TOG, 1, 0);
    tog_step('0, 1, "tog_a1");
    tog_step('0, 0, "tog_a2");
    tog_step('0, 1, "tog_a3");
    tog_step(4'b0010, 0, "tog_clr_act");
    tog_step(4'b0010, 0, "tog_clr_prio");
    tog_step('0, 1, "tog_a4");
    tick(2);

    // isochronous endpoint
    sel_endp = 4'd3;
    tick(2);
    ex_st("iso_mode", F_MODE, 1, 1); ex_st("iso_ready", F_RDY, 1, 1);
    tog_step('0, 0, "iso_a1");
    tog_step('0, 0, "iso_a2");
    tick(2);

    // invalid endpoint routes zeros, act ignored
    sel_endp = 4'd7;
    tick(2);
    ex_st("inv_ready", F_RDY, 1, 0); ex_st("inv_len", F_LEN, 1, 0);
    ex_st("inv_mode", F_MODE, 1, 0); ex_st("inv_tog", F_TOG, 1, 0);
    tog_step('0, 0, "inv_act");
    sel_endp = 4'd1;
    tick(2);
    ex_st("tog_kept", F_TOG, 1, 1);

    // commit ep0, ack after 5 cycles, foreign ack ignored
    sel_endp = 4'd0;
    tick(2);
    buf_in_commit = 1'b1; buf_in_commit_len = 11'd64;
    ex_ev("cmt_pulse", K_CMT, 1, 4'b0001); ex_st("cmt_len", F_CLEN, 1, 64);
    tick(1);
    buf_in_commit = 1'b0; buf_in_commit_len = 11'h7ff;
    tick(1);
    ep_in_commit_ack = 4'b0010;
    tick(1);
    ep_in_commit_ack = '0;
    tick(2);
    ep_in_commit_ack = 4'b0001;
    ex_ev("cmt_ack", K_CACK, 1, 1);
    tick(1);
    ep_in_commit_ack = '0;
    ex_st("cmt_err", F_ERRC, 1, 0);
    tick(2);

    // ack in the same cycle as the commit pulse
    buf_in_commit = 1'b1; buf_in_commit_len = 11'd300;
    ex_ev("cmt2_pulse", K_CMT, 1, 4'b0001); ex_st("cmt2_len", F_CLEN, 1, 300);
    tick(1);
    buf_in_commit = 1'b0;
    ep_in_commit_ack = 4'b0001;
    ex_ev("cmt2_ack", K_CACK, 1, 1);
    tick(1);
    ep_in_commit_ack = '0;
    tick(2);

    // arm ep2 timeout boundary, concurrent commit on ep1
    sel_endp = 4'd2;
    tick(2);
    a = cyc;
    buf_out_arm = 1'b1;
    ex_ev("arm_pulse", K_ARM, 1, 4'b0100);
    tick(1);
    buf_out_arm = 1'b0;
    tick(2);
    sel_endp = 4'd1;
    tick(2);
    buf_in_commit = 1'b1; buf_in_commit_len = 11'd17;
    ex_ev("cc_pulse", K_CMT, 1, 4'b0010); ex_st("cc_len", F_CLEN, 1, 17);
    tick(1);
    buf_in_commit = 1'b0;
    tick(1);
    ep_in_commit_ack = 4'b0010;
    ex_ev("cc_ack", K_CACK, 1, 1);
    tick(1);
    ep_in_commit_ack = '0;
    tick(2);
    sel_endp = 4'd2;
    tick(a + 63 - cyc);
    ex_st("tmo_before", F_ERRA, 1, 0);
    ex_st("tmo_err", F_ERRA, 2, 1);
    tick(2);
    buf_out_arm = 1'b1;
    ex_ev("arm_again", K_ARM, 1, 4'b0100);
    tick(1);
    buf_out_arm = 1'b0;
    tick(1);
    ep_out_arm_ack = 4'b0100;
    ex_ev("arm_ack", K_AACK, 1, 1);
    tick(1);
    ep_out_arm_ack = '0;
    tick(2);

    // invalid commit, then reset clears sticky errors
    sel_endp = 4'd7;
    tick(2);
    buf_in_commit = 1'b1;
    ex_st("inv_cmt_err", F_ERRC, 1, 1);
    tick(1);
    buf_in_commit = 1'b0;
    ex_st("inv_cmt_sticky", F_ERRC, 1, 1);
    tick(1);
    reset_n = 1'b0;
    ex_st("rst_clr_errc", F_ERRC, 1, 0); ex_st("rst_clr_erra", F_ERRA, 1, 0);
    tick(1);
    reset_n = 1'b1;

    // second arm dropped while waiting, reset abandons the handshake
    sel_endp = 4'd2;
    tick(2);
    buf_out_arm = 1'b1;
    ex_ev("drop_pulse", K_ARM, 1, 4'b0100);
    tick(1);
    buf_out_arm = 1'b0;
    tick(8);
    ex_st("drop_before", F_ERRA, 1, 0);
    tick(1);
    buf_out_arm = 1'b1;
    ex_st("drop_err", F_ERRA, 1, 1);
    tick(1);
    buf_out_arm = 1'b0;
    reset_n = 1'b0;
    ex_st("mid_rst_erra", F_ERRA, 1, 0);
    tick(1);
    reset_n = 1'b1;
    ep_out_arm_ack = 4'b0100;
    tick(1);
    ep_out_arm_ack = '0;
    ex_st("mid_rst_quiet", F_ERRA, 3, 0);
    tick(5);
    done = 1'b1;
  end

endmodule
